multicycle_ctrl: RTL and testbench

Multi-cycle control unit sitting directly upstream of the ALU. It sequences each instruction through fetch, decode, execute, memory and write-back. In every state it drives the ALU's operation select and operand muxes, plus all datapath strobes. It handles a variable-latency memory through a ready handshake.

---
 rtl/multicycle_ctrl_pkg.sv | 77 +++++++
 rtl/multicycle_ctrl_decode.sv | 133 +++++++++++++
 rtl/multicycle_ctrl.sv | 112 +++++++++++
 tb/tb_multicycle_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcodes, functs,
// mux select codes and the ALU operation codes it drives.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        STATE_FETCH    = 4'd0,
        STATE_DECODE   = 4'd1,
        STATE_EXEC_R   = 4'd2,
        STATE_WB_R     = 4'd3,
        STATE_EXEC_I   = 4'd4,
        STATE_WB_I     = 4'd5,
        STATE_MEM_ADDR = 4'd6,
        STATE_MEM_RD   = 4'd7,
        STATE_MEM_WB   = 4'd8,
        STATE_MEM_WR   = 4'd9,
        STATE_BRANCH   = 4'd10,
        STATE_JUMP     = 4'd11,
        STATE_ILLEGAL  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SAR  = 6'b000111;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_HIGH = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUB_RT    = 2'b00;
    localparam logic [1:0] ALUB_FOUR  = 2'b01;
    localparam logic [1:0] ALUB_IMM   = 2'b10;
    localparam logic [1:0] ALUB_BROFF = 2'b11;

    localparam logic [2:0] ALU_OP_ADD  = 3'd0;
    localparam logic [2:0] ALU_OP_SUB  = 3'd1;
    localparam logic [2:0] ALU_OP_AND  = 3'd2;
    localparam logic [2:0] ALU_OP_OR   = 3'd3;
    localparam logic [2:0] ALU_OP_LESS = 3'd4;
    localparam logic [2:0] ALU_OP_SAR  = 3'd5;
    localparam logic [2:0] ALU_OP_B    = 3'd6;

    function automatic logic funct_legal(input logic [5:0] funct);
        case (funct)
            FUNCT_ADDU, FUNCT_SUBU, FUNCT_AND,
            FUNCT_OR, FUNCT_SLT, FUNCT_SAR: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] funct_to_alu_op(input logic [5:0] funct);
        case (funct)
            FUNCT_SUBU: return ALU_OP_SUB;
            FUNCT_AND:  return ALU_OP_AND;
            FUNCT_OR:   return ALU_OP_OR;
            FUNCT_SLT:  return ALU_OP_LESS;
            FUNCT_SAR:  return ALU_OP_SAR;
            default:    return ALU_OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational output decoder: maps the current state and instruction
// fields onto every datapath strobe and mux select.
module multicycle_ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic       i_rst,
    input  state_t     i_state,
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    input  logic       i_mem_ready,
    input  logic       i_zero,
    output logic       o_pc_en,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic [1:0] o_pc_source,
    output logic       o_ir_write,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_reg_write,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_ext_op,
    output logic [2:0] o_alu_op,
    output logic       o_flag_write,
    output logic       o_illegal
);

    // Reset gates everything here so a request drops without waiting for an edge.
    always_comb begin
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_pc_source     = PCSRC_ALU;
        o_ir_write      = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_reg_write     = 1'b0;
        o_reg_dst       = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = ALUB_RT;
        o_ext_op        = EXT_ZERO;
        o_alu_op        = ALU_OP_ADD;
        o_flag_write    = 1'b0;
        o_illegal       = 1'b0;
        if (!i_rst) begin
            case (i_state)
                STATE_FETCH: begin
                    o_mem_read  = 1'b1;
                    o_alu_src_b = ALUB_FOUR;
                    if (i_mem_ready) begin
                        o_ir_write  = 1'b1;
                        o_pc_write  = 1'b1;
                        o_pc_source = PCSRC_ALU;
                    end
                end
                STATE_DECODE: begin
                    o_alu_src_b = ALUB_BROFF;
                    o_ext_op    = EXT_SIGN;
                end
                STATE_EXEC_R: begin
                    o_alu_src_a  = 1'b1;
                    o_alu_src_b  = ALUB_RT;
                    o_alu_op     = funct_to_alu_op(i_funct);
                    o_flag_write = 1'b1;
                end
                STATE_WB_R: begin
                    o_reg_write = 1'b1;
                    o_reg_dst   = 1'b1;
                end
                STATE_EXEC_I: begin
                    o_alu_src_a  = 1'b1;
                    o_alu_src_b  = ALUB_IMM;
                    o_flag_write = 1'b1;
                    case (i_op)
                        OP_ORI: begin
                            o_ext_op = EXT_ZERO;
                            o_alu_op = ALU_OP_OR;
                        end
                        OP_LUI: begin
                            o_ext_op = EXT_HIGH;
                            o_alu_op = ALU_OP_B;
                        end
                        default: begin
                            o_ext_op = EXT_SIGN;
                            o_alu_op = ALU_OP_ADD;
                        end
                    endcase
                end
                STATE_WB_I: begin
                    o_reg_write = 1'b1;
                end
                STATE_MEM_ADDR: begin
                    o_alu_src_a = 1'b1;
                    o_alu_src_b = ALUB_IMM;
                    o_ext_op    = EXT_SIGN;
                end
                STATE_MEM_RD: begin
                    o_mem_read = 1'b1;
                end
                STATE_MEM_WB: begin
                    o_reg_write  = 1'b1;
                    o_mem_to_reg = 1'b1;
                end
                STATE_MEM_WR: begin
                    o_mem_write = 1'b1;
                end
                STATE_BRANCH: begin
                    o_alu_src_a     = 1'b1;
                    o_alu_src_b     = ALUB_RT;
                    o_alu_op        = ALU_OP_SUB;
                    o_pc_write_cond = 1'b1;
                    o_pc_source     = PCSRC_ALUOUT;
                    o_flag_write    = 1'b1;
                end
                STATE_JUMP: begin
                    o_pc_write  = 1'b1;
                    o_pc_source = PCSRC_JUMP;
                end
                STATE_ILLEGAL: begin
                    o_illegal = 1'b1;
                end
                default: begin
                    o_illegal = 1'b0;
                end
            endcase
        end
    end

    assign o_pc_en = o_pc_write | (o_pc_write_cond & i_zero);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit: state register and next-state sequencing for
// fetch/decode/execute/memory/write-back, with a variable-latency memory.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_pc_en,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic [1:0] o_pc_source,
    output logic       o_ir_write,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_reg_write,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_ext_op,
    output logic [2:0] o_alu_op,
    output logic       o_flag_write,
    output logic       o_illegal,
    output logic [3:0] o_state
);

    state_t r_state;
    state_t w_next_state;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= STATE_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Memory states hold until mem_ready; ILLEGAL only leaves through reset.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            STATE_FETCH: begin
                if (i_mem_ready) begin
                    w_next_state = STATE_DECODE;
                end
            end
            STATE_DECODE: begin
                case (i_op)
                    OP_RTYPE: w_next_state = funct_legal(i_funct) ? STATE_EXEC_R
                                                                  : STATE_ILLEGAL;
                    OP_LW, OP_SW:            w_next_state = STATE_MEM_ADDR;
                    OP_BEQ:                  w_next_state = STATE_BRANCH;
                    OP_J:                    w_next_state = STATE_JUMP;
                    OP_ADDI, OP_ORI, OP_LUI: w_next_state = STATE_EXEC_I;
                    default:                 w_next_state = STATE_ILLEGAL;
                endcase
            end
            STATE_EXEC_R:   w_next_state = STATE_WB_R;
            STATE_WB_R:     w_next_state = STATE_FETCH;
            STATE_EXEC_I:   w_next_state = STATE_WB_I;
            STATE_WB_I:     w_next_state = STATE_FETCH;
            STATE_MEM_ADDR: w_next_state = (i_op == OP_SW) ? STATE_MEM_WR : STATE_MEM_RD;
            STATE_MEM_RD: begin
                if (i_mem_ready) begin
                    w_next_state = STATE_MEM_WB;
                end
            end
            STATE_MEM_WB:   w_next_state = STATE_FETCH;
            STATE_MEM_WR: begin
                if (i_mem_ready) begin
                    w_next_state = STATE_FETCH;
                end
            end
            STATE_BRANCH:   w_next_state = STATE_FETCH;
            STATE_JUMP:     w_next_state = STATE_FETCH;
            STATE_ILLEGAL:  w_next_state = STATE_ILLEGAL;
            default:        w_next_state = STATE_FETCH;
        endcase
    end

    assign o_state = r_state;

    multicycle_ctrl_decode u_decode (
        .i_rst           (i_rst),
        .i_state         (r_state),
        .i_op            (i_op),
        .i_funct         (i_funct),
        .i_mem_ready     (i_mem_ready),
        .i_zero          (i_zero),
        .o_pc_en         (o_pc_en),
        .o_pc_write      (o_pc_write),
        .o_pc_write_cond (o_pc_write_cond),
        .o_pc_source     (o_pc_source),
        .o_ir_write      (o_ir_write),
        .o_mem_read      (o_mem_read),
        .o_mem_write     (o_mem_write),
        .o_reg_write     (o_reg_write),
        .o_reg_dst       (o_reg_dst),
        .o_mem_to_reg    (o_mem_to_reg),
        .o_alu_src_a     (o_alu_src_a),
        .o_alu_src_b     (o_alu_src_b),
        .o_ext_op        (o_ext_op),
        .o_alu_op        (o_alu_op),
        .o_flag_write    (o_flag_write),
        .o_illegal       (o_illegal)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each driven cycle queues the full
// expected output vector, which is popped and compared mid-cycle.
module tb_multicycle_ctrl;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_WB_R     = 4'd3;
    localparam logic [3:0] S_EXEC_I   = 4'd4;
    localparam logic [3:0] S_WB_I     = 4'd5;
    localparam logic [3:0] S_MEM_ADDR = 4'd6;
    localparam logic [3:0] S_MEM_RD   = 4'd7;
    localparam logic [3:0] S_MEM_WB   = 4'd8;
    localparam logic [3:0] S_MEM_WR   = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_ILLEGAL  = 4'd12;

    localparam logic [2:0] A_ADD  = 3'd0;
    localparam logic [2:0] A_SUB  = 3'd1;
    localparam logic [2:0] A_AND  = 3'd2;
    localparam logic [2:0] A_OR   = 3'd3;
    localparam logic [2:0] A_LESS = 3'd4;
    localparam logic [2:0] A_SAR  = 3'd5;
    localparam logic [2:0] A_B    = 3'd6;

    typedef struct packed {
        logic [3:0] st;
        logic       pcEn;
        logic       pcWrite;
        logic       pcWriteCond;
        logic [1:0] pcSource;
        logic       irWrite;
        logic       memRead;
        logic       memWrite;
        logic       regWrite;
        logic       regDst;
        logic       memToReg;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] extOp;
        logic [2:0] aluOp;
        logic       flagWrite;
        logic       illegal;
    } outs_t;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memReady;
    logic       pcEn, pcWrite, pcWriteCond, irWrite, memRead, memWrite;
    logic       regWrite, regDst, memToReg, aluSrcA, flagWrite, illegal;
    logic [1:0] pcSource, aluSrcB, extOp;
    logic [2:0] aluOp;
    logic [3:0] state;
    outs_t      actual;

    outs_t expQ[$];
    string tagQ[$];
    int    checkCount = 0;
    int    passCount  = 0;

    multicycle_ctrl dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_op            (op),
        .i_funct         (funct),
        .i_zero          (zero),
        .i_mem_ready     (memReady),
        .o_pc_en         (pcEn),
        .o_pc_write      (pcWrite),
        .o_pc_write_cond (pcWriteCond),
        .o_pc_source     (pcSource),
        .o_ir_write      (irWrite),
        .o_mem_read      (memRead),
        .o_mem_write     (memWrite),
        .o_reg_write     (regWrite),
        .o_reg_dst       (regDst),
        .o_mem_to_reg    (memToReg),
        .o_alu_src_a     (aluSrcA),
        .o_alu_src_b     (aluSrcB),
        .o_ext_op        (extOp),
        .o_alu_op        (aluOp),
        .o_flag_write    (flagWrite),
        .o_illegal       (illegal),
        .o_state         (state)
    );

    assign actual = {state, pcEn, pcWrite, pcWriteCond, pcSource, irWrite, memRead,
                     memWrite, regWrite, regDst, memToReg, aluSrcA, aluSrcB, extOp,
                     aluOp, flagWrite, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%07h, expected 0x%07h", tag, observed, expected);
        end
    endtask

    // Expected output vectors per state, written out from the behaviour table.
    function automatic outs_t blank(input logic [3:0] st);
        outs_t e;
        e = '0;
        e.st = st;
        e.aluOp = A_ADD;
        return e;
    endfunction

    function automatic outs_t eFetch(input logic ready);
        outs_t e = blank(S_FETCH);
        e.memRead = 1'b1;
        e.aluSrcB = 2'b01;
        if (ready) begin
            e.irWrite = 1'b1;
            e.pcWrite = 1'b1;
            e.pcEn    = 1'b1;
        end
        return e;
    endfunction

    function automatic outs_t eDecode();
        outs_t e = blank(S_DECODE);
        e.aluSrcB = 2'b11;
        e.extOp   = 2'b01;
        return e;
    endfunction

    function automatic outs_t eExecR(input logic [2:0] alu);
        outs_t e = blank(S_EXEC_R);
        e.aluSrcA   = 1'b1;
        e.aluOp     = alu;
        e.flagWrite = 1'b1;
        return e;
    endfunction

    function automatic outs_t eWbR();
        outs_t e = blank(S_WB_R);
        e.regWrite = 1'b1;
        e.regDst   = 1'b1;
        return e;
    endfunction

    function automatic outs_t eExecI(input logic [1:0] ext, input logic [2:0] alu);
        outs_t e = blank(S_EXEC_I);
        e.aluSrcA   = 1'b1;
        e.aluSrcB   = 2'b10;
        e.extOp     = ext;
        e.aluOp     = alu;
        e.flagWrite = 1'b1;
        return e;
    endfunction

    function automatic outs_t eWbI();
        outs_t e = blank(S_WB_I);
        e.regWrite = 1'b1;
        return e;
    endfunction

    function automatic outs_t eMemAddr();
        outs_t e = blank(S_MEM_ADDR);
        e.aluSrcA = 1'b1;
        e.aluSrcB = 2'b10;
        e.extOp   = 2'b01;
        return e;
    endfunction

    function automatic outs_t eMemRd();
        outs_t e = blank(S_MEM_RD);
        e.memRead = 1'b1;
        return e;
    endfunction

    function automatic outs_t eMemWb();
        outs_t e = blank(S_MEM_WB);
        e.regWrite = 1'b1;
        e.memToReg = 1'b1;
        return e;
    endfunction

    function automatic outs_t eMemWr();
        outs_t e = blank(S_MEM_WR);
        e.memWrite = 1'b1;
        return e;
    endfunction

    function automatic outs_t eBranch(input logic z);
        outs_t e = blank(S_BRANCH);
        e.aluSrcA     = 1'b1;
        e.aluOp       = A_SUB;
        e.pcWriteCond = 1'b1;
        e.pcSource    = 2'b01;
        e.flagWrite   = 1'b1;
        e.pcEn        = z;
        return e;
    endfunction

    function automatic outs_t eJump();
        outs_t e = blank(S_JUMP);
        e.pcWrite  = 1'b1;
        e.pcSource = 2'b10;
        e.pcEn     = 1'b1;
        return e;
    endfunction

    function automatic outs_t eIllegal();
        outs_t e = blank(S_ILLEGAL);
        e.illegal = 1'b1;
        return e;
    endfunction

    // Drive one cycle's inputs just after the rising edge and queue what the DUT should show.
    task automatic applyStimulus(input logic r, input logic [5:0] o, input logic [5:0] f,
                                 input logic ready, input logic z, input outs_t e,
                                 input string tag);
        @(posedge clk);
        #1;
        rst      = r;
        op       = o;
        funct    = f;
        memReady = ready;
        zero     = z;
        expQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            checkOutput(tagQ.pop_front(), 32'(actual), 32'(expQ.pop_front()));
        end
    end

    initial begin
        logic [5:0] rFuncts [5];
        logic [2:0] rOps    [5];
        rFuncts = '{6'b100011, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
        rOps    = '{A_SUB, A_AND, A_OR, A_LESS, A_SAR};

        rst = 1'b1; op = '0; funct = '0; zero = 1'b0; memReady = 1'b0;
        applyStimulus(1, 6'h00, 6'h00, 1, 0, blank(S_FETCH), "reset state");

        applyStimulus(0, 6'b000000, 6'b100001, 1, 0, eFetch(1), "addu fetch");
        applyStimulus(0, 6'b000000, 6'b100001, 1, 0, eDecode(), "addu decode");
        applyStimulus(0, 6'b000000, 6'b100001, 1, 0, eExecR(A_ADD), "addu exec");
        applyStimulus(0, 6'b000000, 6'b100001, 1, 0, eWbR(), "addu wb");

        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 6'b000000, rFuncts[i], 1, 0, eFetch(1), $sformatf("rtype%0d fetch", i));
            applyStimulus(0, 6'b000000, rFuncts[i], 1, 0, eDecode(), $sformatf("rtype%0d decode", i));
            applyStimulus(0, 6'b000000, rFuncts[i], 1, 0, eExecR(rOps[i]), $sformatf("rtype%0d exec", i));
            applyStimulus(0, 6'b000000, rFuncts[i], 1, 0, eWbR(), $sformatf("rtype%0d wb", i));
        end

        applyStimulus(0, 6'b100011, 6'h00, 0, 0, eFetch(0), "lw fetch wait");
        applyStimulus(0, 6'b100011, 6'h00, 1, 0, eFetch(1), "lw fetch");
        applyStimulus(0, 6'b100011, 6'h00, 1, 0, eDecode(), "lw decode");
        applyStimulus(0, 6'b100011, 6'h00, 0, 0, eMemAddr(), "lw addr ignores ready");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 6'b100011, 6'h00, 0, 0, eMemRd(), $sformatf("lw memrd wait%0d", i));
        end
        applyStimulus(0, 6'b100011, 6'h00, 1, 0, eMemRd(), "lw memrd done");
        applyStimulus(0, 6'b100011, 6'h00, 1, 0, eMemWb(), "lw memwb");

        for (int z = 1; z >= 0; z--) begin
            applyStimulus(0, 6'b000100, 6'h00, 1, 1'(z), eFetch(1), $sformatf("beq z%0d fetch", z));
            applyStimulus(0, 6'b000100, 6'h00, 1, 1'(z), eDecode(), $sformatf("beq z%0d decode", z));
            applyStimulus(0, 6'b000100, 6'h00, 1, 1'(z), eBranch(1'(z)), $sformatf("beq z%0d branch", z));
        end

        applyStimulus(0, 6'b000010, 6'h00, 1, 0, eFetch(1), "j fetch");
        applyStimulus(0, 6'b000010, 6'h00, 1, 0, eDecode(), "j decode");
        applyStimulus(0, 6'b000010, 6'h00, 1, 0, eJump(), "j jump");

        applyStimulus(0, 6'b001111, 6'h00, 1, 0, eFetch(1), "lui fetch");
        applyStimulus(0, 6'b001111, 6'h00, 1, 0, eDecode(), "lui decode");
        applyStimulus(0, 6'b001111, 6'h00, 1, 0, eExecI(2'b10, A_B), "lui exec");
        applyStimulus(0, 6'b001111, 6'h00, 1, 0, eWbI(), "lui wb");
        applyStimulus(0, 6'b001101, 6'h00, 1, 0, eFetch(1), "ori fetch");
        applyStimulus(0, 6'b001101, 6'h00, 1, 0, eDecode(), "ori decode");
        applyStimulus(0, 6'b001101, 6'h00, 1, 0, eExecI(2'b00, A_OR), "ori exec");
        applyStimulus(0, 6'b001101, 6'h00, 1, 0, eWbI(), "ori wb");
        applyStimulus(0, 6'b001000, 6'h00, 1, 0, eFetch(1), "addi fetch");
        applyStimulus(0, 6'b001000, 6'h00, 1, 0, eDecode(), "addi decode");
        applyStimulus(0, 6'b001000, 6'h00, 1, 0, eExecI(2'b01, A_ADD), "addi exec");
        applyStimulus(0, 6'b001000, 6'h00, 1, 0, eWbI(), "addi wb");

        applyStimulus(0, 6'b101011, 6'h00, 1, 0, eFetch(1), "sw fetch");
        applyStimulus(0, 6'b101011, 6'h00, 1, 0, eDecode(), "sw decode");
        applyStimulus(0, 6'b101011, 6'h00, 1, 0, eMemAddr(), "sw addr");
        applyStimulus(0, 6'b101011, 6'h00, 0, 0, eMemWr(), "sw memwr wait0");
        applyStimulus(0, 6'b101011, 6'h00, 0, 0, eMemWr(), "sw memwr wait1");
        applyStimulus(1, 6'b101011, 6'h00, 0, 0, blank(S_FETCH), "sw reset mid access");
        applyStimulus(1, 6'b101011, 6'h00, 1, 0, blank(S_FETCH), "sw reset held");
        applyStimulus(0, 6'b101011, 6'h00, 1, 0, eFetch(1), "sw after reset");
        applyStimulus(0, 6'b101011, 6'h00, 1, 0, eDecode(), "sw2 decode");
        applyStimulus(0, 6'b101011, 6'h00, 1, 0, eMemAddr(), "sw2 addr");
        applyStimulus(0, 6'b101011, 6'h00, 1, 0, eMemWr(), "sw2 memwr");

        applyStimulus(0, 6'b111111, 6'h00, 1, 0, eFetch(1), "bad op fetch");
        applyStimulus(0, 6'b111111, 6'h00, 1, 0, eDecode(), "bad op decode");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 6'b111111, 6'h00, 1, 1, eIllegal(), $sformatf("illegal hold%0d", i));
        end
        applyStimulus(1, 6'b000000, 6'h00, 1, 0, blank(S_FETCH), "illegal reset");
        applyStimulus(0, 6'b000000, 6'b000000, 1, 0, eFetch(1), "bad funct fetch");
        applyStimulus(0, 6'b000000, 6'b000000, 1, 0, eDecode(), "bad funct decode");
        applyStimulus(0, 6'b000000, 6'b100001, 1, 0, eIllegal(), "bad funct illegal0");
        applyStimulus(0, 6'b000000, 6'b100001, 1, 0, eIllegal(), "bad funct illegal1");
        applyStimulus(1, 6'b000000, 6'h00, 1, 0, blank(S_FETCH), "bad funct reset");
        applyStimulus(0, 6'b000000, 6'h00, 1, 0, eFetch(1), "final fetch");

        @(negedge clk);
        #1;
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
